// File: rtl/piso_sx8_pkg.sv
// Shared definitions for the 8-bit parallel-in serial-out shifter.
package piso_sx8_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST   = 3'd7;
  localparam logic [CNT_W-1:0] CNT_PENULT = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_sx8_ctl.sv
// Control FSM and bit counter for piso_sx8: decides when a word is taken,
// when the datapath shifts, and when the line returns to idle.
module piso_sx8_ctl
  import piso_sx8_pkg::*;
(
  input  logic CK,
  input  logic RSTN,
  input  logic i_sp,
  input  logic i_load,
  output logic o_rdy,
  output logic o_last,
  output logic o_load,
  output logic o_shift,
  output logic o_done
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              w_at_end;
  logic              w_in_shift;

  assign w_in_shift = (r_state == SHIFT);
  assign w_at_end   = (r_cnt == CNT_LAST);

  // Ready on the final bit too, so a new word can follow with no gap.
  assign o_rdy   = (r_state == IDLE) || (w_in_shift && w_at_end);
  assign o_load  = i_load & o_rdy & i_sp;
  assign o_shift = i_sp & w_in_shift & ~w_at_end;
  assign o_done  = i_sp & w_in_shift & w_at_end & ~o_load;
  assign o_last  = r_last;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (o_load) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (o_shift) begin
      r_cnt   <= r_cnt + 3'd1;
      r_last  <= (r_cnt == CNT_PENULT);
    end else if (o_done) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_sx8.sv
// 8-bit parallel-in serial-out shifter with clock enable and back-to-back
// word reload. Datapath lives here; sequencing is in piso_sx8_ctl.
module piso_sx8
  import piso_sx8_pkg::*;
#(
  parameter logic IDLE_Q    = 1'b1,
  parameter bit   LSB_FIRST = 1'b1
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              SP,
  input  logic [WORD_W-1:0] D,
  input  logic              LOAD,
  output logic              RDY,
  output logic              Q,
  output logic              QV,
  output logic              LAST
);

  logic              w_load;
  logic              w_shift;
  logic              w_done;
  logic [WORD_W-1:0] r_sreg;
  logic              r_q;
  logic              r_qv;

  piso_sx8_ctl u_ctl (
    .CK      (CK),
    .RSTN    (RSTN),
    .i_sp    (SP),
    .i_load  (LOAD),
    .o_rdy   (RDY),
    .o_last  (LAST),
    .o_load  (w_load),
    .o_shift (w_shift),
    .o_done  (w_done)
  );

  // Q is the head of the shift register, so the next bit is read one position in.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_sreg <= '0;
      r_q    <= IDLE_Q;
      r_qv   <= 1'b0;
    end else if (w_load) begin
      r_sreg <= D;
      r_q    <= LSB_FIRST ? D[0] : D[WORD_W-1];
      r_qv   <= 1'b1;
    end else if (w_shift) begin
      if (LSB_FIRST) begin
        r_sreg <= {1'b0, r_sreg[WORD_W-1:1]};
        r_q    <= r_sreg[1];
      end else begin
        r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
        r_q    <= r_sreg[WORD_W-2];
      end
    end else if (w_done) begin
      r_q    <= IDLE_Q;
      r_qv   <= 1'b0;
    end
  end

  assign Q  = r_q;
  assign QV = r_qv;

endmodule

// File: tb/tb_piso_sx8.sv
// Scoreboard bench for piso_sx8: two instances (LSB-first/idle-high and
// MSB-first/idle-low) share stimulus and are checked against a word-level model.
module tb_piso_sx8;

  logic       CK = 1'b0;
  logic       RSTN = 1'b0;
  logic       SP = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] D = 8'h00;

  logic rdy_a, q_a, qv_a, last_a;
  logic rdy_b, q_b, qv_b, last_b;

  int total = 0;
  int bad = 0;
  int qv_cycles = 0;

  typedef struct {
    logic [7:0] w;
    int         idx;
  } bit_t;

  bit_t exp_q[$];
  int   rem = 0;       // bits of the current word still to appear on Q, including this one
  bit   new_bit = 1'b0;
  bit_t cur;

  always #5 CK = ~CK;

  piso_sx8 u_a (
    .CK   (CK),
    .RSTN (RSTN),
    .SP   (SP),
    .D    (D),
    .LOAD (LOAD),
    .RDY  (rdy_a),
    .Q    (q_a),
    .QV   (qv_a),
    .LAST (last_a)
  );

  piso_sx8 #(
    .IDLE_Q    (1'b0),
    .LSB_FIRST (1'b0)
  ) u_b (
    .CK   (CK),
    .RSTN (RSTN),
    .SP   (SP),
    .D    (D),
    .LOAD (LOAD),
    .RDY  (rdy_b),
    .Q    (q_b),
    .QV   (qv_b),
    .LAST (last_b)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word occupies 8 enabled cycles; a new one is taken when
  // at most one bit of the previous word remains.
  initial begin
    forever begin
      @(posedge CK or negedge RSTN);
      if (!RSTN) begin
        rem = 0;
        new_bit = 1'b0;
        exp_q.delete();
      end else if (SP) begin
        if (LOAD && rem <= 1) begin
          for (int i = 0; i < 8; i++) exp_q.push_back('{w: D, idx: i});
          rem = 8;
        end else if (rem > 0) begin
          rem--;
        end
        new_bit = (rem > 0);
      end else begin
        new_bit = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge, pops one expected bit per new bit.
  initial begin
    forever begin
      @(negedge CK);
      chk("rdy_a", rdy_a, rem <= 1);
      chk("rdy_b", rdy_b, rem <= 1);
      chk("qv_a", qv_a, rem > 0);
      chk("qv_b", qv_b, rem > 0);
      if (qv_a) qv_cycles++;
      if (rem > 0) begin
        if (new_bit) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got a new bit expected none at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("q_a", q_a, cur.w[cur.idx]);
        chk("q_b", q_b, cur.w[7-cur.idx]);
        chk("last_a", last_a, cur.idx == 7);
        chk("last_b", last_b, cur.idx == 7);
      end else begin
        chk("idle_q_a", q_a, 8'd1);
        chk("idle_q_b", q_b, 8'd0);
        chk("idle_last_a", last_a, 8'd0);
        chk("idle_last_b", last_b, 8'd0);
      end
    end
  end

  task automatic drive(input logic sp, input logic ld, input logic [7:0] d);
    SP = sp;
    LOAD = ld;
    D = d;
    @(posedge CK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    RSTN = 1'b0;
    repeat (2) @(posedge CK);
    #2;
    RSTN = 1'b1;

    // Single word, LSB first on u_a, MSB first on u_b
    drive(1'b1, 1'b1, 8'hA5);
    idle(10);

    // Back-to-back reload with LOAD held through LAST
    qv_cycles = 0;
    drive(1'b1, 1'b1, 8'h81);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'h3C);
    idle(10);
    chk("b2b_qv_cycles", qv_cycles[7:0], 8'd16);

    // Clock-enable gap stretches bit 2
    qv_cycles = 0;
    drive(1'b1, 1'b1, 8'hFF);
    idle(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    idle(10);
    chk("sp_gap_qv_cycles", qv_cycles[7:0], 8'd11);

    // LOAD while busy is dropped
    drive(1'b1, 1'b1, 8'hF0);
    idle(3);
    drive(1'b1, 1'b1, 8'h00);
    idle(10);

    // Asynchronous reset mid-word at bit 5
    drive(1'b1, 1'b1, 8'h6B);
    idle(5);
    #1 RSTN = 1'b0;
    #1;
    chk("arst_q_a", q_a, 8'd1);
    chk("arst_q_b", q_b, 8'd0);
    chk("arst_qv", qv_a, 8'd0);
    chk("arst_last", last_a, 8'd0);
    chk("arst_rdy", rdy_a, 8'd1);
    @(posedge CK);
    #2 RSTN = 1'b1;
    idle(10);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0), 8'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #1 RSTN = 1'b0;
        @(posedge CK);
        #2 RSTN = 1'b1;
      end
    end
    idle(12);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_sx8.md
PISO_SX8 -- requirements
Module: piso_sx8

Interface
REQ-001 Parameter IDLE_Q, default 1'b1: level driven on Q while no word is being shifted.
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 is sent first; 0 = bit 7 is sent first.
REQ-003 CK  input  1  clock; all state changes on the rising edge.
REQ-004 RSTN  input  1  reset; asynchronous, active-low.
REQ-005 SP  input  1  clock enable; when low, all state holds.
REQ-006 D  input  8  parallel word to transmit.
REQ-007 LOAD  input  1  word-valid strobe for D.
REQ-008 RDY  output  1  block can accept a word this cycle.
REQ-009 Q  output  1  serial data out, registered.
REQ-010 QV  output  1  Q carries a valid data bit, registered.
REQ-011 LAST  output  1  Q carries bit 8 of 8 of the current word, registered.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT; cnt is a 3-bit bit counter.
REQ-013 RDY SHALL be combinational: 1 in IDLE, or in SHIFT with cnt==7; otherwise 0.
REQ-014 Accept = LOAD & RDY & SP; D SHALL be sampled only on an accepting edge.
REQ-015 Accepting edge: load shift register with D; Q = first bit; QV=1; cnt=0; state=SHIFT.
REQ-016 Latency: first bit SHALL appear on Q in the cycle after the accepting edge.
REQ-017 In SHIFT with SP=1 and cnt<7: shift by one, Q = next bit, cnt+1, QV stays 1.
REQ-018 LAST SHALL be 1 exactly while cnt==7 in SHIFT; otherwise 0.
REQ-019 cnt==7, SP=1, no accept: go to IDLE; Q=IDLE_Q; QV=0; LAST=0.
REQ-020 cnt==7, SP=1, with accept: reload back-to-back with no idle gap; Q shows first bit of the new word.
REQ-021 LOAD while RDY=0 SHALL be ignored; no word is queued.
REQ-022 SP=0 SHALL freeze Q, QV, LAST, cnt, the shift register and the state. LOAD is ignored.
REQ-023 With SP held high, one word SHALL occupy exactly 8 consecutive cycles of QV=1.
REQ-024 SP gaps SHALL stretch the bit period without losing or repeating bits.

Reset
REQ-025 RSTN low SHALL take effect immediately, independent of CK and SP.
REQ-026 Reset values: state=IDLE, cnt=0, shift register=0, Q=IDLE_Q, QV=0, LAST=0; RDY therefore 1.
REQ-027 Reset mid-word SHALL abort the word; no remaining bits are sent after release.
REQ-028 The first accept is permitted on the first rising edge after RSTN is released.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=1'b0, SHIFT=1'b1) and the word-width constant 8.
REQ-030 One sub-module, piso_sx8_ctl, SHALL hold the FSM and counter and produce RDY, LAST, load and shift.
REQ-031 The datapath (shift register, Q, QV) SHALL stay in the top module.

Verification
REQ-032 Reset, then D=8'hA5, LOAD=1 for one cycle, SP=1, LSB_FIRST=1:
- Q = 1,0,1,0,0,1,0,1 over 8 cycles.
- QV=1 for those 8 cycles; LAST=1 on cycle 8 only.
- Afterwards Q=1 (IDLE_Q) and QV=0.
REQ-033 LSB_FIRST=0, D=8'h81:
- Q = 1,0,0,0,0,0,0,1.
- Then 8'h3C loaded with LOAD held through LAST.
- Q = 0,0,1,1,1,1,0,0 follows with no gap; QV stays 1 for 16 cycles.
REQ-034 D=8'hFF, SP low for 3 cycles after bit 2:
- Q holds bit 2 for 4 cycles total.
- Total QV-high cycles = 11.
- All 8 ones are sent once each.
REQ-035 LOAD pulsed with D=8'h00 at bit 4 of word 8'hF0: ignored.
- Word 8'hF0 completes unchanged.
- IDLE follows, not a second word.
REQ-036 RSTN low mid-cycle at bit 5:
- Q=IDLE_Q, QV=0, LAST=0, RDY=1 at once, without a CK edge.
- No further bits are sent after release.
REQ-037 IDLE_Q=0: Q=0 in reset and in IDLE.
